// File: rtl/data_memory_controller.sv
// data_memory_controller: memory-side responder for the data cache.
// A read request returns the 16-word block that holds the missed address,
// starting with the missed word and wrapping, one beat per cycle. A write
// request commits a single word. Both arrive after a fixed access latency.
module data_memory_controller #(
    parameter int MEM_WORDS       = 4096,
    parameter int LATENCY         = 4,
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [31:0]                        req_address,
    input  logic [31:0]                        req_wdata,
    output logic                               resp_valid,
    output logic [31:0]                        resp_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] resp_word,
    output logic                               resp_last,
    output logic                               wr_done,
    output logic                               busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic [4:0]       BEATS      = 5'(WORDS_PER_BLOCK);
    localparam logic [4:0]       LAST_BEAT  = 5'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        BURST  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     lat_cnt_reg, lat_cnt_next;
    logic [4:0]           beat_cnt_reg, beat_cnt_next;

    // Request captured at accept; held until the controller returns to IDLE.
    logic                 wr_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [31:0]          wdata_reg;

    logic                 resp_valid_reg;
    logic [31:0]          resp_data_reg;
    logic [OFF_W-1:0]     resp_word_reg;
    logic                 resp_last_reg;
    logic                 wr_done_reg;

    logic                 accept;
    logic                 beat_fire;
    logic                 commit_fire;
    logic [OFF_W-1:0]     rd_word;
    logic [IDX_W-1:0]     rd_addr;

    logic [31:0]          mem [MEM_WORDS];

    // Byte-lane bits and the aliased upper address bits play no part.
    logic                 unused_addr;
    assign unused_addr = ^{req_address[31:IDX_W+2], req_address[1:0]};

    // Beat k reads (start + k) mod block size inside the missed block.
    assign rd_word = idx_reg[OFF_W-1:0] + beat_cnt_reg[OFF_W-1:0];
    assign rd_addr = {idx_reg[IDX_W-1:OFF_W], rd_word};

    assign req_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_word  = resp_word_reg;
    assign resp_last  = resp_last_reg;
    assign wr_done    = wr_done_reg;

    // State register plus latency and beat counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            lat_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lat_cnt_reg  <= lat_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state logic. WAIT lasts exactly LATENCY cycles, so the edge that
    // leaves it registers the first beat (or the commit) in cycle T+LATENCY.
    // BURST stays one extra cycle after the last issue so resp_last is
    // visible while busy; IDLE follows immediately after it.
    always_comb begin
        state_next    = state_reg;
        lat_cnt_next  = lat_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        accept        = 1'b0;
        beat_fire     = 1'b0;
        commit_fire   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept        = 1'b1;
                    state_next    = WAIT;
                    lat_cnt_next  = LAT_LOAD;
                    beat_cnt_next = '0;
                end
            end
            WAIT: begin
                if (lat_cnt_reg == '0) begin
                    if (wr_reg) begin
                        commit_fire = 1'b1;
                        state_next  = COMMIT;
                    end else begin
                        beat_fire     = 1'b1;
                        beat_cnt_next = beat_cnt_reg + 5'd1;
                        state_next    = BURST;
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg - CNT_W'(1);
                end
            end
            BURST: begin
                if (beat_cnt_reg == BEATS) begin
                    state_next = IDLE;
                end else begin
                    beat_fire     = 1'b1;
                    beat_cnt_next = beat_cnt_reg + 5'd1;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            wr_reg    <= req_write;
            idx_reg   <= req_address[IDX_W+1:2];
            wdata_reg <= req_wdata;
        end
    end

    // Registered response: array read lands directly in resp_data; data and
    // word hold their last beat values between bursts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_word_reg  <= '0;
            resp_last_reg  <= 1'b0;
            wr_done_reg    <= 1'b0;
        end else begin
            resp_valid_reg <= beat_fire;
            resp_last_reg  <= beat_fire && (beat_cnt_reg == LAST_BEAT);
            wr_done_reg    <= commit_fire;
            if (beat_fire) begin
                resp_data_reg <= mem[rd_addr];
                resp_word_reg <= rd_word;
            end
        end
    end

    // Array write port; contents survive reset, and an aborted write never
    // reaches here because reset forces the FSM back to IDLE.
    always_ff @(posedge clock) begin
        if (commit_fire) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller: two instances (LATENCY=4 and
// LATENCY=1). Stimulus pushes expected beats/commits with their cycle stamps,
// a negedge monitor pops and compares whenever a DUT presents an output.
module tb_data_memory_controller;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_write   [2];
    logic [31:0] req_address [2];
    logic [31:0] req_wdata   [2];
    logic        resp_valid  [2];
    logic [31:0] resp_data   [2];
    logic [3:0]  resp_word   [2];
    logic        resp_last   [2];
    logic        wr_done     [2];
    logic        busy        [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat [2] = '{4, 1};

    typedef struct {
        bit          is_wr;
        int          cyc;
        logic [3:0]  word;
        logic [31:0] data;
        bit          known;
        bit          last;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] model [int];

    data_memory_controller #(.MEM_WORDS(4096), .LATENCY(4), .WORDS_PER_BLOCK(16)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_address(req_address[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]), .resp_word(resp_word[0]),
        .resp_last(resp_last[0]), .wr_done(wr_done[0]), .busy(busy[0])
    );

    data_memory_controller #(.MEM_WORDS(4096), .LATENCY(1), .WORDS_PER_BLOCK(16)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_address(req_address[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]), .resp_word(resp_word[1]),
        .resp_last(resp_last[1]), .wr_done(wr_done[1]), .busy(busy[1])
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int sel, input exp_t e);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Expected responses for one accepted request (accept stamp t).
    task automatic expect_txn(input int sel, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int t);
        exp_t e;
        int   idx;
        int   base;
        int   start;
        int   w;
        idx   = int'(addr[13:2]);
        base  = idx & ~15;
        start = idx & 15;
        if (wr) begin
            model[sel * 65536 + idx] = wdata;
            e = '{is_wr: 1'b1, cyc: t + lat[sel], word: 4'd0, data: 32'd0, known: 1'b0, last: 1'b0};
            push_exp(sel, e);
        end else begin
            for (int k = 0; k < 16; k++) begin
                w = (start + k) & 15;
                e.is_wr = 1'b0;
                e.cyc   = t + lat[sel] + k;
                e.word  = 4'(w);
                e.known = model.exists(sel * 65536 + base + w);
                e.data  = e.known ? model[sel * 65536 + base + w] : 32'd0;
                e.last  = (k == 15);
                push_exp(sel, e);
            end
        end
    endtask

    // Present a request, wait (bounded) for the accept, record the accept stamp.
    task automatic issue(input int sel, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int t);
        int n;
        @(negedge clock);
        req_valid[sel]   = 1'b1;
        req_write[sel]   = wr;
        req_address[sel] = addr;
        req_wdata[sel]   = wdata;
        n = 0;
        while (!req_ready[sel] && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("accept_ready", 32'(req_ready[sel]), 32'd1);
        @(negedge clock);
        t = cyc;
        req_valid[sel] = 1'b0;
        expect_txn(sel, wr, addr, wdata, t);
    endtask

    task automatic wait_drain(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 32'((sel == 0) ? q0.size() : q1.size()), 32'd0);
    endtask

    // Monitor: one comparison set per presented beat or commit.
    task automatic mon(input int sel);
        exp_t e;
        bit   empty;
        chk("last_implies_valid", 32'(resp_last[sel] & ~resp_valid[sel]), 32'd0);
        if (resp_valid[sel] || wr_done[sel]) begin
            empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output dut%0d actual valid=%0b wr_done=%0b required none (cycle %0d)",
                         sel, resp_valid[sel], wr_done[sel], cyc);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d_cycle", sel), 32'(cyc), 32'(e.cyc));
                chk($sformatf("dut%0d_wr_done", sel), 32'(wr_done[sel]), 32'(e.is_wr));
                chk($sformatf("dut%0d_resp_valid", sel), 32'(resp_valid[sel]), 32'(!e.is_wr));
                if (!e.is_wr) begin
                    chk($sformatf("dut%0d_resp_word", sel), 32'(resp_word[sel]), 32'(e.word));
                    chk($sformatf("dut%0d_resp_last", sel), 32'(resp_last[sel]), 32'(e.last));
                    if (e.known) chk($sformatf("dut%0d_resp_data", sel), resp_data[sel], e.data);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int t;
        int t2;
        int n;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]   = 1'b0;
            req_write[s]   = 1'b0;
            req_address[s] = '0;
            req_wdata[s]   = '0;
        end
        #3 reset = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state of both instances.
        for (int s = 0; s < 2; s++) begin
            chk("rst_req_ready",  32'(req_ready[s]),  32'd1);
            chk("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            chk("rst_resp_data",  resp_data[s],       32'd0);
            chk("rst_resp_word",  32'(resp_word[s]),  32'd0);
            chk("rst_resp_last",  32'(resp_last[s]),  32'd0);
            chk("rst_wr_done",    32'(wr_done[s]),    32'd0);
            chk("rst_busy",       32'(busy[s]),       32'd0);
        end
        reset = 1'b1;

        // Preload block 0x40 with 0xA000_0000 + i through write requests.
        for (int i = 0; i < 16; i++)
            issue(0, 1'b1, (32'h40 + 32'(i)) << 2, 32'hA000_0000 + 32'(i), t);
        wait_drain(0);

        // Aligned refill: words 0..15, beats at T+4..T+19.
        issue(0, 1'b0, 32'h0000_0100, 32'd0, t);
        wait_drain(0);

        // Critical word first from word 13, wrapping 15 -> 0.
        issue(0, 1'b0, 32'h0000_0134, 32'd0, t);
        wait_drain(0);

        // Write-through then refill of the same block.
        issue(0, 1'b1, 32'h0000_0208, 32'hDEAD_BEEF, t);
        issue(0, 1'b0, 32'h0000_0200, 32'd0, t);
        wait_drain(0);

        // req_valid held high: ready low across WAIT/BURST, re-accept right after.
        @(negedge clock);
        req_valid[0]   = 1'b1;
        req_write[0]   = 1'b0;
        req_address[0] = 32'h0000_0100;
        n = 0;
        while (!req_ready[0] && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        t = cyc;
        expect_txn(0, 1'b0, 32'h0000_0100, 32'd0, t);
        n = 0;
        while (!req_ready[0] && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("ready_low_span", 32'(cyc), 32'(t + 20));
        @(negedge clock);
        t2 = cyc;
        req_valid[0] = 1'b0;
        chk("second_accept", 32'(t2), 32'(t + 21));
        expect_txn(0, 1'b0, 32'h0000_0100, 32'd0, t2);
        wait_drain(0);

        // Reset during the fifth beat aborts the burst.
        issue(0, 1'b0, 32'h0000_0100, 32'd0, t);
        n = 0;
        while (cyc < t + 8 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("beat5_seen", 32'(resp_word[0]), 32'd4);
        #2 reset = 1'b0;
        q0.delete();
        @(negedge clock);
        chk("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort_resp_data",  resp_data[0],       32'd0);
        chk("abort_resp_word",  32'(resp_word[0]),  32'd0);
        chk("abort_resp_last",  32'(resp_last[0]),  32'd0);
        chk("abort_busy",       32'(busy[0]),       32'd0);
        reset = 1'b1;
        repeat (25) @(negedge clock);
        chk("abort_req_ready",  32'(req_ready[0]),  32'd1);

        // LATENCY=1 instance: preload block 0, then back-to-back refill from T+1.
        for (int i = 0; i < 16; i++)
            issue(1, 1'b1, 32'(i) << 2, 32'hB000_0000 + 32'(i), t);
        issue(1, 1'b0, 32'h0000_0000, 32'd0, t);
        wait_drain(1);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
